// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the sequenced reset generator.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    RESET,
    HOLD,
    RELEASE,
    RUN
  } reset_seq_state_t;

  localparam int unsigned MAX_STAGES = 8;

  // Larger of two unsigned values, used to size the shared interval counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the
// second clock edge after the asynchronous reset is released.
module rst_sync (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic srst_n_o
);

  logic [1:0] sync_q;

  // Shift a constant one through the chain; any low on arst_n_i clears it at once.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign srst_n_o = sync_q[1];

endmodule

// File: rtl/reset_seq.sv
// Sequenced reset generator: waits for a sustained clock lock, then releases
// the downstream resets one stage at a time and flags ready at the end.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned STAGE_GAP   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_locked,
  input  logic              sw_rst,
  output logic [STAGES-1:0] rst_o,
  output logic              ready
);

  localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, STAGE_GAP);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = $clog2(STAGES) + 1;

  // Reject parameter sets the sequencer cannot honour.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_seq: HOLD_CYCLES must be at least 1");
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("reset_seq: STAGES must be in 1..8");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_seq: STAGE_GAP must be at least 1");
  end

  logic rst_n_sync;

  reset_seq_state_t  state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              ready_q, ready_d;
  logic              abort_c;

  // Local release of the asynchronous reset, aligned to clk.
  rst_sync u_rst_sync (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .srst_n_o (rst_n_sync)
  );

  assign abort_c = !clk_locked || sw_rst;

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and next-output logic; stages are released LSB first by shifting in zeros.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    case (state_q)
      RESET: begin
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        if (!abort_c) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (abort_c) begin
          state_d = RESET;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          rst_d = rst_q << 1;
          if (STAGES == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (abort_c) begin
          state_d = RESET;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          rst_d = rst_q << 1;
          if (idx_q == IDX_W'(STAGES - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (abort_c) begin
          state_d = RESET;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = RESET;
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign rst_o = rst_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus queues expected outputs per clock
// edge, a negedge monitor pops and compares them.
module tb_reset_seq;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       clk_locked = 1'b0;
  logic       sw_rst     = 1'b0;
  logic [2:0] rst0;
  logic       rdy0;
  logic [0:0] rst1;
  logic       rdy1;

  always #5 clk = ~clk;

  // Main configuration from the test plan.
  reset_seq #(.HOLD_CYCLES(8), .STAGES(3), .STAGE_GAP(4)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_locked (clk_locked),
    .sw_rst     (sw_rst),
    .rst_o      (rst0),
    .ready      (rdy0)
  );

  // Single-stage, single-cycle-hold corner case.
  reset_seq #(.HOLD_CYCLES(1), .STAGES(1), .STAGE_GAP(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_locked (clk_locked),
    .sw_rst     (sw_rst),
    .rst_o      (rst1),
    .ready      (rdy1)
  );

  // Rising-edge counter; stable when read at the falling edge.
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct {
    int         cyc;
    bit         dut;
    logic [2:0] rst;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [2:0] act_r, input logic act_y,
                       input logic [2:0] exp_r, input logic exp_y);
    n_chk++;
    if (act_r !== exp_r || act_y !== exp_y) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got rst_o=%b ready=%b, want rst_o=%b ready=%b",
               name, ecnt, act_r, act_y, exp_r, exp_y);
    end
  endtask

  // Insert keeping the queue ordered by edge number.
  task automatic sb_push(input int c, input bit d, input logic [2:0] r, input logic y,
                         input string n);
    exp_t e;
    int   i;
    e.cyc = c; e.dut = d; e.rst = r; e.rdy = y; e.name = n;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  task automatic to_edge(input int c);
    while (ecnt < c) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at the current edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
      e = sb.pop_front();
      if (e.cyc < ecnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: expectation for edge %0d not sampled (now %0d)", e.name, e.cyc, ecnt);
      end else if (e.dut) begin
        check(e.name, {2'b00, rst1}, rdy1, e.rst, e.rdy);
      end else begin
        check(e.name, rst0, rdy0, e.rst, e.rdy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got edge %0d want finish", ecnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, a, b, c;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    n = ecnt;
    sb_push(n + 1, 0, 3'b111, 1'b0, "reset_state");
    sb_push(n + 1, 1, 3'b001, 1'b0, "reset_state_s1");
    to_edge(n + 1);

    // Basic release: E0 lands on the third edge after rst_n rises.
    n = ecnt;
    rst_n      = 1'b1;
    clk_locked = 1'b1;
    sb_push(n + 2,  0, 3'b111, 1'b0, "sync_latency");
    sb_push(n + 3,  1, 3'b001, 1'b0, "s1_e0");
    sb_push(n + 4,  1, 3'b000, 1'b1, "s1_e1_ready");
    sb_push(n + 10, 0, 3'b111, 1'b0, "basic_e7");
    sb_push(n + 11, 0, 3'b110, 1'b0, "basic_e8");
    sb_push(n + 14, 0, 3'b110, 1'b0, "basic_e11");
    sb_push(n + 15, 0, 3'b100, 1'b0, "basic_e12");
    sb_push(n + 18, 0, 3'b100, 1'b0, "basic_e15");
    sb_push(n + 19, 0, 3'b000, 1'b1, "basic_e16");
    to_edge(n + 21);

    // Software reset pulse in RUN.
    m = ecnt;
    sw_rst = 1'b1;
    sb_push(m + 1, 0, 3'b111, 1'b0, "swrst_abort");
    sb_push(m + 1, 1, 3'b001, 1'b0, "swrst_abort_s1");
    to_edge(m + 1);
    sw_rst = 1'b0;
    sb_push(m + 3,  1, 3'b000, 1'b1, "s1_rerelease");
    sb_push(m + 9,  0, 3'b111, 1'b0, "swrst_e7");
    sb_push(m + 10, 0, 3'b110, 1'b0, "swrst_e8");
    sb_push(m + 14, 0, 3'b100, 1'b0, "swrst_e12");
    sb_push(m + 17, 0, 3'b100, 1'b0, "swrst_e15");
    sb_push(m + 18, 0, 3'b000, 1'b1, "swrst_e16");
    to_edge(m + 20);

    // Lock loss in RUN, then a one-cycle lock glitch at E5 of HOLD.
    a = ecnt;
    clk_locked = 1'b0;
    sb_push(a + 1, 0, 3'b111, 1'b0, "lockloss_run");
    to_edge(a + 1);
    clk_locked = 1'b1;
    to_edge(a + 6);
    clk_locked = 1'b0;
    sb_push(a + 7, 0, 3'b111, 1'b0, "hold_glitch");
    to_edge(a + 7);
    clk_locked = 1'b1;
    sb_push(a + 10, 0, 3'b111, 1'b0, "hold_no_resume");
    sb_push(a + 15, 0, 3'b111, 1'b0, "hold_restart_e7");
    sb_push(a + 16, 0, 3'b110, 1'b0, "hold_restart_e8");
    sb_push(a + 20, 0, 3'b100, 1'b0, "midrel_e12");
    sb_push(a + 21, 0, 3'b100, 1'b0, "midrel_e13");
    to_edge(a + 21);

    // Lock loss mid-release, sampled at E14.
    clk_locked = 1'b0;
    sb_push(a + 22, 0, 3'b111, 1'b0, "midrel_abort_e14");
    to_edge(a + 22);
    clk_locked = 1'b1;
    sb_push(a + 30, 0, 3'b111, 1'b0, "relock_e7");
    sb_push(a + 31, 0, 3'b110, 1'b0, "relock_e8");
    sb_push(a + 35, 0, 3'b100, 1'b0, "relock_e12");
    sb_push(a + 39, 0, 3'b000, 1'b1, "relock_e16");
    to_edge(a + 41);

    // Asynchronous reset between edges while a release is in progress.
    b = ecnt;
    sw_rst = 1'b1;
    to_edge(b + 1);
    sw_rst = 1'b0;
    sb_push(b + 10, 0, 3'b110, 1'b0, "pre_async_e8");
    to_edge(b + 10);
    #2 rst_n = 1'b0;
    #1;
    check("async_assert", rst0, rdy0, 3'b111, 1'b0);
    check("async_assert_s1", {2'b00, rst1}, rdy1, 3'b001, 1'b0);
    to_edge(b + 12);

    // Release after async reset: E0 no earlier than the third edge.
    c = ecnt;
    rst_n = 1'b1;
    sb_push(c + 2,  0, 3'b111, 1'b0, "async_sync_lat");
    sb_push(c + 3,  1, 3'b001, 1'b0, "s1_async_e0");
    sb_push(c + 4,  1, 3'b000, 1'b1, "s1_async_e1");
    sb_push(c + 10, 0, 3'b111, 1'b0, "async_e7");
    sb_push(c + 11, 0, 3'b110, 1'b0, "async_e8");
    sb_push(c + 15, 0, 3'b100, 1'b0, "async_e12");
    sb_push(c + 19, 0, 3'b000, 1'b1, "async_e16");
    to_edge(c + 21);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
